// File: rtl/mnist_nn_pkg.sv
// Shared parameters, types and the Q8.8 saturation helper for the MNIST NN layer engine.
package mnist_nn_pkg;

  localparam int N_LANES = 20;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 8;
  localparam int ACC_W   = 40;
  localparam int RAM_LAT = 2;
  localparam int PROD_W  = 2 * DATA_W;

  typedef logic signed [DATA_W-1:0] q88_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} mac_state_e;

  typedef struct packed {
    logic valid;
    logic is_bias;
  } tag_t;

  localparam acc_t SAT_HI = acc_t'((2 ** (DATA_W - 1)) - 1);
  localparam acc_t SAT_LO = -acc_t'(2 ** (DATA_W - 1));

  // Drop the extra fraction bits (floor) and clamp into the Q8.8 range.
  function automatic q88_t sat_q88(input acc_t acc);
    acc_t shifted;
    shifted = acc >>> FRAC_W;
    if (shifted > SAT_HI) begin
      return q88_t'(SAT_HI[DATA_W-1:0]);
    end
    if (shifted < SAT_LO) begin
      return q88_t'(SAT_LO[DATA_W-1:0]);
    end
    return q88_t'(shifted[DATA_W-1:0]);
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// One neuron lane: product register, accumulator and saturated output register.
// Define RELU_EN to clamp negative outputs to zero (hidden layers).
module neuron_mac
  import mnist_nn_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  q88_t w_q,
  input  q88_t io_q,
  input  logic q_valid,
  input  logic q_is_bias,
  input  logic p_valid,
  input  logic load,
  output q88_t result
);

  prod_t w_ext;
  prod_t x_ext;
  prod_t prod;
  acc_t  acc;
  q88_t  sat_val;
  q88_t  out_val;

  assign w_ext = prod_t'(w_q);
  assign x_ext = prod_t'(io_q);

  // The bias word shares the weight port and is lifted to Q16.16 to line up with products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod <= '0;
    end else if (q_valid) begin
      prod <= q_is_bias ? (w_ext <<< FRAC_W) : (w_ext * x_ext);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (p_valid) begin
      acc <= acc + acc_t'(prod);
    end
  end

  always_comb begin
    sat_val = sat_q88(acc);
`ifdef RELU_EN
    out_val = sat_val[DATA_W-1] ? '0 : sat_val;
`else
    out_val = sat_val;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else if (load) begin
      result <= out_val;
    end
  end

endmodule

// File: rtl/layer_mac_engine.sv
// Fully-connected layer engine: FSM, lockstep address generation, tag pipe and N_LANES MAC lanes.
// Output ReLU is selected at build time with RELU_EN.
module layer_mac_engine
  import mnist_nn_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] N_In,
  input  logic [ADDR_W-1:0] In_Base,
  output logic [ADDR_W-1:0] W_Addr [N_LANES-1:0],
  input  logic [DATA_W-1:0] W_Q [N_LANES-1:0],
  output logic [ADDR_W-1:0] IO_Addr,
  input  logic [DATA_W-1:0] IO_Q,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Result [N_LANES-1:0]
);

  mac_state_e               state;
  logic [ADDR_W-1:0]        k;
  logic [ADDR_W-1:0]        k_next;
  logic [ADDR_W-1:0]        n_in_r;
  logic [ADDR_W-1:0]        base_r;
  tag_t [RAM_LAT-1:0]       tag_pipe;
  tag_t                     issue_tag;
  logic                     prod_valid;
  logic                     pipe_empty;
  logic                     accept;
  logic                     load;

  assign k_next = k + 1'b1;
  assign accept = (state == IDLE) && Start;
  assign load   = (state == DRAIN) && pipe_empty;
  assign Busy   = (state != IDLE);
  assign Done   = (state == FINISH);

  always_comb begin
    issue_tag         = '0;
    issue_tag.valid   = (state == FETCH);
    issue_tag.is_bias = (state == FETCH) && (k == n_in_r);
  end

  always_comb begin
    pipe_empty = !prod_valid;
    for (int i = 0; i < RAM_LAT; i++) begin
      if (tag_pipe[i].valid) begin
        pipe_empty = 1'b0;
      end
    end
  end

  always_comb begin
    for (int n = 0; n < N_LANES; n++) begin
      W_Addr[n] = k;
    end
  end

  // Tags ride alongside the RAM read latency so each lane knows when Q is a weight or the bias.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tag_pipe   <= '0;
      prod_valid <= 1'b0;
    end else begin
      tag_pipe   <= {tag_pipe[RAM_LAT-2:0], issue_tag};
      prod_valid <= tag_pipe[RAM_LAT-1].valid;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      k       <= '0;
      n_in_r  <= '0;
      base_r  <= '0;
      IO_Addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            n_in_r  <= N_In;
            base_r  <= In_Base;
            k       <= '0;
            IO_Addr <= In_Base;
            state   <= FETCH;
          end
        end
        FETCH: begin
          if (k == n_in_r) begin
            state <= DRAIN;
          end else begin
            k       <= k_next;
            IO_Addr <= base_r + k_next;
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  for (genvar n = 0; n < N_LANES; n++) begin : g_lane
    neuron_mac u_lane (
      .clk       (Clk),
      .rst       (Reset),
      .clear     (accept),
      .w_q       (W_Q[n]),
      .io_q      (IO_Q),
      .q_valid   (tag_pipe[RAM_LAT-1].valid),
      .q_is_bias (tag_pipe[RAM_LAT-1].is_bias),
      .p_valid   (prod_valid),
      .load      (load),
      .result    (Result[n])
    );
  end

endmodule
